axis_frame_pad_8: RTL and testbench

- 8-bit AXI-Stream frame length conditioner placed directly downstream of the 64-to-8 axis_adapter.
- Pads short frames with 0x00 bytes up to MIN_LENGTH.
- Truncates long frames at MAX_LENGTH and discards the rest of the input frame.
- Reports per-frame length and pad/truncate status on a side channel.

---
 rtl/axis_frame_pad_8.sv | 236 +++++++++++++++++++++++
 tb/tb_axis_frame_pad_8.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_pad_8.sv
// rtl/axis_frame_pad_8.sv - 8-bit AXI-Stream frame conditioner: pads short frames, truncates long ones
// Status side channel is built only when FRAME_PAD_STATUS_EN is defined.

module axis_frame_pad_8 #(
  parameter int MIN_LENGTH = 60,
  parameter int MAX_LENGTH = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  input_axis_tdata,
  input  logic        input_axis_tkeep,
  input  logic        input_axis_tvalid,
  output logic        input_axis_tready,
  input  logic        input_axis_tlast,
  input  logic        input_axis_tuser,
  output logic [7:0]  output_axis_tdata,
  output logic        output_axis_tkeep,
  output logic        output_axis_tvalid,
  input  logic        output_axis_tready,
  output logic        output_axis_tlast,
  output logic        output_axis_tuser,
  output logic        status_valid,
  output logic        status_frame_pad,
  output logic        status_frame_truncate,
  output logic [15:0] status_frame_length,
  output logic [15:0] status_frame_original_length
);

  localparam logic [15:0] MIN_L = 16'(MIN_LENGTH);
  localparam logic [15:0] MAX_L = 16'(MAX_LENGTH);

  typedef enum logic [1:0] {
    S_TRANSFER = 2'd0,
    S_PAD      = 2'd1,
    S_TRUNCATE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tkeep_q, tkeep_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        tuser_lat_q, tuser_lat_d;
  logic [15:0] cnt_out_q, cnt_out_d;

  logic        ld, in_ready, in_acc;
  logic [15:0] cnt_out_inc;
  logic        end_evt, end_pad, end_trunc, in_cnt_inc;
  logic [15:0] end_len;

  assign ld = output_axis_tready | ~tvalid_q;

  always_comb begin
    case (state_q)
      S_TRANSFER: in_ready = ld;
      S_TRUNCATE: in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

  assign input_axis_tready = rst & in_ready;
  assign in_acc            = input_axis_tvalid & input_axis_tready;
  assign cnt_out_inc       = cnt_out_q + {15'd0, input_axis_tkeep};

  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tuser_lat_d = tuser_lat_q;
    cnt_out_d   = cnt_out_q;
    end_evt     = 1'b0;
    end_pad     = 1'b0;
    end_trunc   = 1'b0;
    end_len     = cnt_out_q;
    in_cnt_inc  = 1'b0;
    if (ld) tvalid_d = 1'b0;
    case (state_q)
      S_TRANSFER: begin
        if (in_acc) begin
          in_cnt_inc = input_axis_tkeep;
          cnt_out_d  = cnt_out_inc;
          // tkeep=0 beats are only forwarded when they close the frame
          if (input_axis_tkeep || input_axis_tlast) begin
            tdata_d  = input_axis_tdata;
            tkeep_d  = input_axis_tkeep;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
          end
          if (input_axis_tlast) begin
            if (cnt_out_inc < MIN_L) begin
              tuser_lat_d = input_axis_tuser;
              state_d     = S_PAD;
            end else begin
              tlast_d   = 1'b1;
              tuser_d   = input_axis_tuser;
              end_evt   = 1'b1;
              end_len   = cnt_out_inc;
              cnt_out_d = 16'd0;
            end
          end else if (input_axis_tkeep && cnt_out_inc == MAX_L) begin
            tlast_d = 1'b1;
            tuser_d = input_axis_tuser;
            state_d = S_TRUNCATE;
          end
        end
      end
      S_PAD: begin
        if (ld) begin
          tdata_d   = 8'h00;
          tkeep_d   = 1'b1;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tuser_d   = 1'b0;
          cnt_out_d = cnt_out_q + 16'd1;
          if (cnt_out_q + 16'd1 == MIN_L) begin
            tlast_d   = 1'b1;
            tuser_d   = tuser_lat_q;
            end_evt   = 1'b1;
            end_pad   = 1'b1;
            end_len   = cnt_out_q + 16'd1;
            cnt_out_d = 16'd0;
            state_d   = S_TRANSFER;
          end
        end
      end
      S_TRUNCATE: begin
        if (in_acc) begin
          in_cnt_inc = input_axis_tkeep;
          if (input_axis_tlast) begin
            end_evt   = 1'b1;
            end_trunc = 1'b1;
            end_len   = cnt_out_q;
            cnt_out_d = 16'd0;
            state_d   = S_TRANSFER;
          end
        end
      end
      default: state_d = S_TRANSFER;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_TRANSFER;
      tdata_q     <= 8'h00;
      tkeep_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      tuser_lat_q <= 1'b0;
      cnt_out_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tuser_lat_q <= tuser_lat_d;
      cnt_out_q   <= cnt_out_d;
    end
  end

  assign output_axis_tdata  = tdata_q;
  assign output_axis_tkeep  = tkeep_q;
  assign output_axis_tvalid = tvalid_q;
  assign output_axis_tlast  = tlast_q;
  assign output_axis_tuser  = tuser_q;

`ifdef FRAME_PAD_STATUS_EN
  logic [15:0] cnt_in_q, cnt_in_d, cnt_in_sum;
  logic        st_valid_q, st_valid_d;
  logic        st_pad_q, st_pad_d;
  logic        st_trunc_q, st_trunc_d;
  logic [15:0] st_len_q, st_len_d;
  logic [15:0] st_orig_q, st_orig_d;

  // original length saturates rather than wrapping on huge input frames
  assign cnt_in_sum = (cnt_in_q == 16'hFFFF) ? cnt_in_q : cnt_in_q + {15'd0, in_cnt_inc};

  always_comb begin
    cnt_in_d   = cnt_in_sum;
    st_valid_d = end_evt;
    st_pad_d   = st_pad_q;
    st_trunc_d = st_trunc_q;
    st_len_d   = st_len_q;
    st_orig_d  = st_orig_q;
    if (end_evt) begin
      cnt_in_d   = 16'd0;
      st_pad_d   = end_pad;
      st_trunc_d = end_trunc;
      st_len_d   = end_len;
      st_orig_d  = cnt_in_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_in_q   <= 16'd0;
      st_valid_q <= 1'b0;
      st_pad_q   <= 1'b0;
      st_trunc_q <= 1'b0;
      st_len_q   <= 16'd0;
      st_orig_q  <= 16'd0;
    end else begin
      cnt_in_q   <= cnt_in_d;
      st_valid_q <= st_valid_d;
      st_pad_q   <= st_pad_d;
      st_trunc_q <= st_trunc_d;
      st_len_q   <= st_len_d;
      st_orig_q  <= st_orig_d;
    end
  end

  assign status_valid                 = st_valid_q;
  assign status_frame_pad             = st_pad_q;
  assign status_frame_truncate        = st_trunc_q;
  assign status_frame_length          = st_len_q;
  assign status_frame_original_length = st_orig_q;
`else
  logic unused_status;
  assign unused_status = ^{end_evt, end_pad, end_trunc, end_len, in_cnt_inc};

  assign status_valid                 = 1'b0;
  assign status_frame_pad             = 1'b0;
  assign status_frame_truncate        = 1'b0;
  assign status_frame_length          = 16'd0;
  assign status_frame_original_length = 16'd0;
`endif

endmodule

// File: tb/tb_axis_frame_pad_8.sv
// tb/tb_axis_frame_pad_8.sv - directed self-checking bench for axis_frame_pad_8
// dut0: MIN 8 / MAX 16, dut1: MIN 4 / MAX 6; status expectations follow FRAME_PAD_STATUS_EN.

module tb_axis_frame_pad_8;

`ifdef FRAME_PAD_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  i_tdata [2];
  logic        i_tkeep [2], i_tvalid [2], i_tlast [2], i_tuser [2], in_rdy [2];
  logic [7:0]  o_tdata [2];
  logic        o_tkeep [2], o_tvalid [2], o_tlast [2], o_tuser [2], out_rdy [2];
  logic        st_valid [2], st_pad [2], st_trunc [2];
  logic [15:0] st_len [2], st_orig [2];

  int          checks = 0;
  int          errors = 0;
  int          pulses [2];
  logic [10:0] obs0 [$], obs1 [$], exp_q [$];
  logic [11:0] held [2];
  bit          held_v [2];
  bit          stall_en = 1'b0;

  axis_frame_pad_8 #(.MIN_LENGTH(8), .MAX_LENGTH(16)) dut0 (
    .clk(clk), .rst(rst),
    .input_axis_tdata(i_tdata[0]), .input_axis_tkeep(i_tkeep[0]), .input_axis_tvalid(i_tvalid[0]),
    .input_axis_tready(in_rdy[0]), .input_axis_tlast(i_tlast[0]), .input_axis_tuser(i_tuser[0]),
    .output_axis_tdata(o_tdata[0]), .output_axis_tkeep(o_tkeep[0]), .output_axis_tvalid(o_tvalid[0]),
    .output_axis_tready(out_rdy[0]), .output_axis_tlast(o_tlast[0]), .output_axis_tuser(o_tuser[0]),
    .status_valid(st_valid[0]), .status_frame_pad(st_pad[0]), .status_frame_truncate(st_trunc[0]),
    .status_frame_length(st_len[0]), .status_frame_original_length(st_orig[0])
  );

  axis_frame_pad_8 #(.MIN_LENGTH(4), .MAX_LENGTH(6)) dut1 (
    .clk(clk), .rst(rst),
    .input_axis_tdata(i_tdata[1]), .input_axis_tkeep(i_tkeep[1]), .input_axis_tvalid(i_tvalid[1]),
    .input_axis_tready(in_rdy[1]), .input_axis_tlast(i_tlast[1]), .input_axis_tuser(i_tuser[1]),
    .output_axis_tdata(o_tdata[1]), .output_axis_tkeep(o_tkeep[1]), .output_axis_tvalid(o_tvalid[1]),
    .output_axis_tready(out_rdy[1]), .output_axis_tlast(o_tlast[1]), .output_axis_tuser(o_tuser[1]),
    .status_valid(st_valid[1]), .status_frame_pad(st_pad[1]), .status_frame_truncate(st_trunc[1]),
    .status_frame_length(st_len[1]), .status_frame_original_length(st_orig[1])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] cur_beat(int d);
    return {o_tlast[d], o_tuser[d], o_tkeep[d], o_tdata[d]};
  endfunction

  function automatic int obs_size(int d);
    return (d == 0) ? obs0.size() : obs1.size();
  endfunction

  function automatic logic [10:0] obs_at(int d, int i);
    return (d == 0) ? obs0[i] : obs1[i];
  endfunction

  // Output monitor: records handshakes and checks that stalled beats stay frozen
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (o_tvalid[d] && out_rdy[d]) begin
        if (d == 0) obs0.push_back(cur_beat(d));
        else        obs1.push_back(cur_beat(d));
      end
      if (st_valid[d]) pulses[d]++;
      if (held_v[d]) chk($sformatf("stall_hold%0d", d), {20'd0, o_tvalid[d], cur_beat(d)}, {20'd0, held[d]});
      held_v[d] = o_tvalid[d] && !out_rdy[d];
      held[d]   = {o_tvalid[d], cur_beat(d)};
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_en) out_rdy[0] = 1'($urandom_range(0, 1));
  end

  task automatic ex(logic [7:0] data, logic keep, logic last, logic user);
    exp_q.push_back({last, user, keep, data});
  endtask

  task automatic send_beat(int d, logic [7:0] data, logic keep, logic last, logic user);
    bit acc = 1'b0;
    i_tdata[d]  = data;
    i_tkeep[d]  = keep;
    i_tlast[d]  = last;
    i_tuser[d]  = user;
    i_tvalid[d] = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_rdy[d];
      @(posedge clk);
      #1;
    end
    i_tvalid[d] = 1'b0;
    chk($sformatf("accept%0d_%02h", d, data), {31'd0, acc}, 32'd1);
  endtask

  task automatic send_seq(int d, logic [7:0] first, int n, logic user_last);
    for (int i = 0; i < n; i++)
      send_beat(d, first + 8'(i), 1'b1, (i == n - 1), (i == n - 1) ? user_last : 1'b0);
  endtask

  task automatic check_frame(int d, string tag);
    int n = 0;
    while (obs_size(d) < exp_q.size() && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_count"}, obs_size(d), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_size(d); i++)
      chk($sformatf("%s_beat%0d", tag, i), {21'd0, obs_at(d, i)}, {21'd0, exp_q[i]});
    exp_q.delete();
    if (d == 0) obs0.delete();
    else        obs1.delete();
  endtask

  task automatic check_status(int d, string tag, int npulse, logic pad, logic trunc, int len, int orig);
    chk({tag, "_pulses"}, pulses[d], ST ? npulse : 0);
    chk({tag, "_pad"}, {31'd0, st_pad[d]}, {31'd0, pad & ST});
    chk({tag, "_trunc"}, {31'd0, st_trunc[d]}, {31'd0, trunc & ST});
    chk({tag, "_length"}, {16'd0, st_len[d]}, ST ? len : 0);
    chk({tag, "_orig"}, {16'd0, st_orig[d]}, ST ? orig : 0);
    pulses[d] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      i_tdata[d] = 8'h00; i_tkeep[d] = 1'b0; i_tvalid[d] = 1'b0;
      i_tlast[d] = 1'b0;  i_tuser[d] = 1'b0; out_rdy[d] = 1'b1;
      pulses[d] = 0;      held_v[d] = 1'b0;  held[d] = 12'd0;
    end
    #12;
    chk("rst_tvalid", {31'd0, o_tvalid[0]}, 32'd0);
    chk("rst_tdata", {24'd0, o_tdata[0]}, 32'd0);
    chk("rst_tready", {31'd0, in_rdy[0]}, 32'd0);
    chk("rst_status_valid", {31'd0, st_valid[1]}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tready", {31'd0, in_rdy[0]}, 32'd1);

    // short frame padded to MIN with latched tuser on the final pad byte
    send_beat(0, 8'hcd, 1, 0, 0); send_beat(0, 8'hab, 1, 0, 0); send_beat(0, 8'hcd, 1, 0, 0);
    send_beat(0, 8'hab, 1, 0, 0); send_beat(0, 8'hcd, 1, 1, 1);
    ex(8'hcd, 1, 0, 0); ex(8'hab, 1, 0, 0); ex(8'hcd, 1, 0, 0); ex(8'hab, 1, 0, 0); ex(8'hcd, 1, 0, 0);
    ex(8'h00, 1, 0, 0); ex(8'h00, 1, 0, 0); ex(8'h00, 1, 1, 1);
    check_frame(0, "pad");
    check_status(0, "pad_st", 1, 1, 0, 8, 5);

    // 9-byte frame truncated at 6; tuser of discarded last byte ignored
    send_seq(1, 8'h01, 9, 1);
    for (int i = 1; i <= 6; i++) ex(8'(i), 1, (i == 6), 0);
    check_frame(1, "trunc");
    check_status(1, "trunc_st", 1, 0, 1, 6, 9);

    // exactly MAX bytes: unchanged
    send_seq(1, 8'h11, 6, 0);
    for (int i = 0; i < 6; i++) ex(8'h11 + 8'(i), 1, (i == 5), 0);
    check_frame(1, "exact");
    check_status(1, "exact_st", 1, 0, 0, 6, 6);

    // back-to-back: MAX-length frame with tuser, then a 2-byte padded frame
    send_seq(1, 8'h21, 6, 1);
    send_seq(1, 8'h31, 2, 0);
    for (int i = 0; i < 6; i++) ex(8'h21 + 8'(i), 1, (i == 5), (i == 5));
    ex(8'h31, 1, 0, 0); ex(8'h32, 1, 0, 0); ex(8'h00, 1, 0, 0); ex(8'h00, 1, 1, 0);
    check_frame(1, "b2b");
    check_status(1, "b2b_st", 2, 1, 0, 4, 2);

    // padded frame under random downstream stalls
    stall_en = 1'b1;
    send_seq(0, 8'ha1, 3, 0);
    ex(8'ha1, 1, 0, 0); ex(8'ha2, 1, 0, 0); ex(8'ha3, 1, 0, 0);
    for (int i = 0; i < 5; i++) ex(8'h00, 1, (i == 4), 0);
    check_frame(0, "stall");
    stall_en = 1'b0;
    @(posedge clk); #2; out_rdy[0] = 1'b1;
    @(posedge clk); #1;
    check_status(0, "stall_st", 1, 1, 0, 8, 3);

    // tkeep=0 beats dropped mid-frame, tkeep=0 tlast beat forwarded
    send_beat(0, 8'h41, 1, 0, 0);
    send_beat(0, 8'h42, 0, 0, 0);
    for (int i = 3; i <= 9; i++) send_beat(0, 8'h40 + 8'(i), 1, 0, 0);
    send_beat(0, 8'h4a, 0, 1, 0);
    ex(8'h41, 1, 0, 0);
    for (int i = 3; i <= 9; i++) ex(8'h40 + 8'(i), 1, 0, 0);
    ex(8'h4a, 0, 1, 0);
    check_frame(0, "keep0");
    check_status(0, "keep0_st", 1, 0, 0, 8, 8);

    // asynchronous reset mid-frame
    send_seq(0, 8'h71, 3, 0);
    #2; rst = 1'b0;
    #1;
    chk("midrst_tvalid", {31'd0, o_tvalid[0]}, 32'd0);
    chk("midrst_tdata", {24'd0, o_tdata[0]}, 32'd0);
    chk("midrst_tready", {31'd0, in_rdy[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #3; rst = 1'b1;
    obs0.delete();
    pulses[0] = 0;
    @(posedge clk); #1;
    send_seq(0, 8'h61, 5, 0);
    for (int i = 0; i < 5; i++) ex(8'h61 + 8'(i), 1, 0, 0);
    ex(8'h00, 1, 0, 0); ex(8'h00, 1, 0, 0); ex(8'h00, 1, 1, 0);
    check_frame(0, "after_rst");
    check_status(0, "after_rst_st", 1, 1, 0, 8, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
